// File: rtl/grid_rmw_sequencer.sv
// Read-modify-write sequencer for the gridding accumulate path.
// Each accepted request issues a double-word BRAM read, then strobes the adder
// input, then strobes the write-back with the combinator offset. Requests whose
// window overlaps an op that has not yet written back are held off.
module grid_rmw_sequencer #(
    parameter int BRAM_PARALLELISM_BITS = 4,
    parameter int BRAM_DEPTH_BITS       = 10,
    parameter int RD_LATENCY            = 2,
    parameter int ADD_LATENCY           = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       enable,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [BRAM_DEPTH_BITS+BRAM_PARALLELISM_BITS-1:0] in_addr,
    output logic                                       bram_rd_en,
    output logic [BRAM_DEPTH_BITS-1:0]                 bram_rd_addr,
    output logic                                       adder_in_valid,
    output logic [BRAM_PARALLELISM_BITS-1:0]           comb_addr,
    output logic                                       bram_wr_en,
    output logic [BRAM_DEPTH_BITS-1:0]                 bram_wr_addr,
    output logic                                       idle,
    output logic [31:0]                                op_count,
    output logic [31:0]                                stall_count
);

    localparam int DEPTH = RD_LATENCY + ADD_LATENCY + 1;
    localparam int DW    = BRAM_DEPTH_BITS;
    localparam int PW    = BRAM_PARALLELISM_BITS;

    // Slot k holds the op that is k+1 cycles past acceptance; the last slot
    // is the op writing back in the current cycle.
    logic [DEPTH-1:0] slot_valid;
    logic [DW-1:0]    slot_word [DEPTH];
    logic [PW-1:0]    slot_off  [DEPTH];

    logic [DW-1:0] req_word;
    logic [PW-1:0] req_off;
    logic          hazard;
    logic          accept;

    assign req_word = in_addr[DW+PW-1:PW];
    assign req_off  = in_addr[PW-1:0];

    // Two double-word windows overlap when their base words differ by -1, 0 or +1
    // modulo the BRAM depth (top word and word 0 are adjacent).
    function automatic logic windows_overlap(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] d;
        d = a - b;
        return (d == {DW{1'b0}}) || (d == DW'(1)) || (d == {DW{1'b1}});
    endfunction

    // Hazard against every op still ahead of its write-back; the op writing
    // this cycle is excluded so a dependent request can be accepted alongside it.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (slot_valid[k] && windows_overlap(req_word, slot_word[k])) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready       = enable && !hazard && !rst;
    assign accept         = in_valid && in_ready;
    assign bram_rd_en     = slot_valid[0];
    assign adder_in_valid = slot_valid[RD_LATENCY];
    assign bram_wr_en     = slot_valid[DEPTH-1];
    assign idle           = (slot_valid == {DEPTH{1'b0}});

    // Tracking shift register, advancing every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_word[k] <= '0;
                slot_off[k]  <= '0;
            end
        end else begin
            slot_valid   <= {slot_valid[DEPTH-2:0], accept};
            slot_word[0] <= req_word;
            slot_off[0]  <= req_off;
            for (int k = 1; k < DEPTH; k++) begin
                slot_word[k] <= slot_word[k-1];
                slot_off[k]  <= slot_off[k-1];
            end
        end
    end

    // Address outputs load alongside their strobe and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_rd_addr <= '0;
            bram_wr_addr <= '0;
            comb_addr    <= '0;
        end else begin
            if (accept) begin
                bram_rd_addr <= req_word;
            end
            if (slot_valid[DEPTH-2]) begin
                bram_wr_addr <= slot_word[DEPTH-2];
                comb_addr    <= slot_off[DEPTH-2];
            end
        end
    end

    // Completed write-back and requester stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count    <= '0;
            stall_count <= '0;
        end else begin
            if (bram_wr_en) begin
                op_count <= op_count + 32'd1;
            end
            if (in_valid && !in_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/grid_rmw_sequencer.md
Name: grid_rmw_sequencer

Overview:
- Control sequencer for the gridding accumulate path: BRAM read of a double-word window -> adder -> combinator merge -> BRAM write-back.
- Accepts one accumulate request per cycle (sample address = word index + in-word offset) and times the BRAM read enable, adder input strobe, combinator offset select and write-back enable.
- Detects read-after-write hazards between overlapping windows and stalls the requester.
- Carries no sample data; data flows bram -> adder -> combinator directly.

Parameters:
- BRAM_PARALLELISM_BITS, 4, log2 of complex samples per BRAM word; width of in-word offset.
- BRAM_DEPTH_BITS, 10, BRAM word-address width.
- RD_LATENCY, 2, BRAM read latency in cycles (>=1).
- ADD_LATENCY, 4, adder pipeline latency in cycles (>=1).
- DEPTH (derived), RD_LATENCY+ADD_LATENCY+1, number of in-flight tracking slots.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = accept requests; 0 = stop accepting, let in-flight ops drain.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge.
- in_addr  in  BRAM_DEPTH_BITS+BRAM_PARALLELISM_BITS  upper bits = word index w, lower bits = offset.
- bram_rd_en  out  1  read strobe; BRAM returns {word w+1, word w} as one double-width word.
- bram_rd_addr  out  BRAM_DEPTH_BITS  word index w.
- adder_in_valid  out  1  BRAM data valid at adder input this cycle.
- comb_addr  out  BRAM_PARALLELISM_BITS  offset select for combinator, aligned with adder output.
- bram_wr_en  out  1  write-back strobe for merged double word.
- bram_wr_addr  out  BRAM_DEPTH_BITS  write-back word index w.
- idle  out  1  no op in flight.
- op_count  out  32  completed write-backs, wraps at 2^32.
- stall_count  out  32  cycles with in_valid && !in_ready, wraps at 2^32.

Behaviour:
- Reset: all outputs 0 except idle=1; tracking slots cleared. Reset mid-operation discards all in-flight ops; no wr_en after reset.
- Timing (A = acceptance cycle):
  - bram_rd_en=1, bram_rd_addr=w during A+1.
  - adder_in_valid=1 during A+1+RD_LATENCY.
  - bram_wr_en=1, bram_wr_addr=w, comb_addr=offset during A+1+RD_LATENCY+ADD_LATENCY.
  - Strobes are one cycle wide; addr outputs hold their last value when strobe low.
- Tracking: DEPTH-slot shift register of {valid, w, offset}, advancing every cycle unconditionally. There is no backpressure downstream.
- Hazard: request word w conflicts with tracked op w' if (w - w') mod 2^BRAM_DEPTH_BITS is in {0, 1, 2^BRAM_DEPTH_BITS-1}.
  - Check against every op whose write cycle is later than the current cycle.
  - Wrap-around: top word and word 0 are adjacent.
- in_ready = enable && !hazard. Combinational from in_addr and slot state; must not depend on in_valid.
- Throughput: non-conflicting requests accepted back-to-back, 1/cycle. A conflicting request waits. It is accepted in the same cycle the blocking op's bram_wr_en is high, so its read issues on the following cycle.
- Simultaneous events: write of op X and acceptance of a dependent op Y in the same cycle is legal and required.
- idle = no valid slot. op_count increments with each bram_wr_en. stall_count increments on in_valid && !in_ready, including when enable=0.
- enable falling: in-flight ops complete normally; idle rises after last write.

Test Plan:
- Single op: after reset, in_addr=0x035 accepted at A -> rd_en at A+1, rd_addr=3; adder_in_valid at A+3; wr_en at A+7, wr_addr=3, comb_addr=5; op_count=1; idle=1 from A+8.
- Back-to-back independent: in_addr 0x000, 0x020, 0x040, 0x060 on consecutive cycles -> all accepted without stall; wr_addr 0,2,4,6 on four consecutive cycles; stall_count=0.
- RAW stall: 0x030 accepted at A, then 0x040 (word 4, adjacent) presented at A+1 -> in_ready=0 through A+6, accepted at A+7, its rd_en at A+8; stall_count=6.
- Wrap-around: 0x3FF0 (word 1023) in flight, then 0x0000 -> stalled until the 1023 write; 0x0020 (word 2) behind 0x3FF0 -> no stall.
- enable/reset: three ops in flight, enable=0 -> in_ready=0, three wr_en still occur, idle=1 afterwards. Separately, rst at A+3 of an op -> no wr_en ever issued, op_count=0.
